div_arbiter: RTL and testbench
==============================

# div_arbiter

Shared-divider arbiter and sequencer for the 8-bit ALU. It accepts divide requests from `NREQ` requesters and grants the single sequential SRT divider to one of them at a time, round-robin. It latches the winner's operands, drives the divider's start/done handshake and returns the quotient and remainder tagged with the requester index. It short-circuits divide-by-zero and recovers from a hung divider via a watchdog.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (2..4).
- `W`, 8: operand/result width.
- `TIMEOUT`, 64: maximum cycles spent in WAIT before the operation is abandoned.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  NREQ  per-requester request level; held until the matching `ack` bit.
- `req_dividend`  in  NREQ*W  packed dividends; slice i belongs to requester i.
- `req_divisor`  in  NREQ*W  packed divisors.
- `ack`  out  NREQ  one-hot, one-cycle pulse; operands are latched on this cycle.
- `resp_valid`  out  1  one-cycle result pulse.
- `resp_id`  out  clog2(NREQ)  index of the requester owning the response.
- `resp_quotient`  out  W  result quotient.
- `resp_remainder`  out  W  result remainder.
- `resp_dz`  out  1  divide-by-zero flag.
- `resp_err`  out  1  watchdog timeout flag.
- `div_start`  out  1  one-cycle start pulse to the divider.
- `div_abort`  out  1  one-cycle pulse that resets the divider after a timeout.
- `div_dividend`  out  W  divider operand; held stable from ISSUE until the divider returns.
- `div_divisor`  out  W  divider operand; held stable from ISSUE until the divider returns.
- `div_done`  in  1  divider completion; may be a pulse or a level.
- `div_quotient`  in  W  divider quotient; valid while `div_done` is high.
- `div_remainder`  in  W  divider remainder; valid while `div_done` is high.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, with `req` nonzero:
  - Pick the first set bit at or above `rr_ptr`, wrapping around.
  - Pulse that `ack` bit, latch the requester's operands and index.
  - Go to RESP if the divisor is 0, otherwise go to ISSUE.
- ISSUE: `div_start`=1 for exactly one cycle. Clear the watchdog counter. Go to WAIT.
- WAIT:
  - On the first cycle `div_done`=1, latch `div_quotient`/`div_remainder` and go to RESP.
  - Otherwise increment the watchdog. When it reaches `TIMEOUT-1`, pulse `div_abort`, set the error flag, zero both results and go to RESP.
- RESP:
  - `resp_valid`=1 with the latched results and flags.
  - Set `rr_ptr` to the granted index + 1, modulo NREQ.
  - Go to IDLE.
- Divide-by-zero: `resp_quotient`=all ones, `resp_remainder`=dividend, `resp_dz`=1. No `div_start` is issued.
- `div_done` is ignored outside WAIT. A level-style done that is still high from the previous operation must not complete the next one, because ISSUE separates them.
- Requests deasserted before `ack` are dropped silently. `req` is not sampled outside IDLE.
- All outputs are registered.

## Timing
- Reset values:
  - `ack`, `resp_valid`, `resp_id`, `resp_quotient`, `resp_remainder`, `resp_dz`, `resp_err` = 0.
  - `div_start`, `div_abort`, `div_dividend`, `div_divisor` = 0.
  - State is IDLE and `rr_ptr` = 0.
- Cycle counts:
  - `ack` appears on the edge after `req` is seen in IDLE.
  - `div_start` appears 1 cycle after `ack`.
  - `resp_valid` appears 1 cycle after the `div_done` sample.
  - The divide-by-zero response appears 1 cycle after `ack`.
- Throughput: the next `ack` is issued at the earliest in the cycle after `resp_valid`. There is no pipelining or backpressure; consumers must take `resp_valid` when it pulses.
- Simultaneous `div_done` and watchdog expiry: `div_done` wins and `resp_err`=0.
- A reset asserted mid-operation aborts it immediately and clears all outputs. No response is produced for the in-flight request, which must re-request.

## Structure
- Shared package `alu_pkg`: width constant `ALU_W`=8, the FSM state enum, and the divide-by-zero quotient constant.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are `req` and `rr_ptr`; outputs are a one-hot grant and a valid flag.
- The divider itself stays external and connects only through the `div_*` ports.

## Test plan
- Single request, req0 59/6 (0x3B/0x06) with a divider model of 10-cycle latency: `ack`=01, one `div_start`, then `resp_valid` with id 0, q=9, r=5, dz=0, err=0.
- `req`=11 held continuously with different operands: grants alternate 0,1,0,1; each `resp_id` matches the preceding `ack`; no second `ack` before the prior `resp_valid`.
- req1 0x2A/0x00: `ack`=10 and no `div_start`. One cycle later `resp_valid` with q=0xFF, r=0x2A, dz=1.
- Divider stub that never asserts `div_done`, TIMEOUT=64: `div_abort` pulses on the 64th WAIT cycle, then `resp_err`=1 with q=0 and r=0. The next request proceeds normally.
- `div_done` held high permanently from a prior operation, then a new request: completion occurs only in WAIT, one cycle after ISSUE, with the new results.
- `rst` asserted during WAIT: all outputs are 0 in the same cycle and no `resp_valid` is produced. After release, `req`=01 is acked normally.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 8-bit ALU blocks.
//   ALU_W        : native operand/result width of the ALU datapath.
//   arb_state_t  : state encoding of the shared-divider arbiter sequencer.
//   DZ_QUOTIENT  : quotient reported for a divide-by-zero (all ones).
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   localparam logic [ALU_W-1:0] DZ_QUOTIENT = {ALU_W{1'b1}};

endpackage : alu_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: grants the first set request bit at or
// above rr_ptr, wrapping around to bit 0.
// Ports:
//   req     in  NREQ  request vector
//   rr_ptr  in  IDW   index with highest priority this round
//   grant   out NREQ  one-hot grant (zero when no request)
//   valid   out 1     at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  rr_ptr,
   output logic [NREQ-1:0] grant,
   output logic            valid
);

   always_comb begin
      grant = '0;
      valid = 1'b0;
      // Walk the requesters starting at rr_ptr; the first hit wins.
      for (int k = 0; k < NREQ; k++) begin
         if (!valid && req[(int'(rr_ptr) + k) % NREQ]) begin
            grant[(int'(rr_ptr) + k) % NREQ] = 1'b1;
            valid = 1'b1;
         end
      end
   end

endmodule : rr_pick

// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
// Round-robin arbiter and sequencer for one shared sequential divider.
// A granted requester's operands are latched on its ack pulse, the divider is
// started, and the quotient/remainder come back tagged with the requester id.
// Divide-by-zero is answered locally; a hung divider is aborted by a watchdog.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req / req_dividend / req_divisor   per-requester level request + operands
//   ack                      one-hot grant pulse (operands latched)
//   resp_valid/id/quotient/remainder/dz/err   one-cycle tagged result
//   div_start/div_abort      divider control pulses
//   div_dividend/div_divisor divider operands, stable for the whole operation
//   div_done/div_quotient/div_remainder   divider completion and results
// -----------------------------------------------------------------------------
module div_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int W       = ALU_W,
   parameter int TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*W-1:0]         req_dividend,
   input  logic [NREQ*W-1:0]         req_divisor,
   output logic [NREQ-1:0]           ack,
   output logic                      resp_valid,
   output logic [$clog2(NREQ)-1:0]   resp_id,
   output logic [W-1:0]              resp_quotient,
   output logic [W-1:0]              resp_remainder,
   output logic                      resp_dz,
   output logic                      resp_err,
   output logic                      div_start,
   output logic                      div_abort,
   output logic [W-1:0]              div_dividend,
   output logic [W-1:0]              div_divisor,
   input  logic                      div_done,
   input  logic [W-1:0]              div_quotient,
   input  logic [W-1:0]              div_remainder
);

   localparam int IDW    = $clog2(NREQ);
   localparam int WDW    = $clog2(TIMEOUT) + 1;
   // Widen the all-ones constant so any W gets a full all-ones quotient.
   localparam int DZ_REP = (W + ALU_W - 1) / ALU_W;
   localparam logic [DZ_REP*ALU_W-1:0] DZ_WIDE = {DZ_REP{DZ_QUOTIENT}};

   arb_state_t        state_reg;
   logic [IDW-1:0]    rr_ptr_reg;
   logic [IDW-1:0]    id_reg;
   logic [W-1:0]      dividend_reg;
   logic              dz_reg;
   logic [WDW-1:0]    wd_reg;

   logic [W-1:0]      dividend_arr [NREQ];
   logic [W-1:0]      divisor_arr  [NREQ];
   logic [NREQ-1:0]   pick_grant;
   logic              pick_valid;
   logic [IDW-1:0]    pick_idx;
   logic [W-1:0]      pick_dividend;
   logic [W-1:0]      pick_divisor;

   // Unpack the flat operand buses into per-requester slices.
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign dividend_arr[gi] = req_dividend[gi*W +: W];
         assign divisor_arr[gi]  = req_divisor[gi*W +: W];
      end
   endgenerate

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_pick (
      .req    (req),
      .rr_ptr (rr_ptr_reg),
      .grant  (pick_grant),
      .valid  (pick_valid)
   );

   // One-hot grant to index and operand select.
   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_grant[i]) begin
            pick_idx = IDW'(i);
         end
      end
   end

   assign pick_dividend = dividend_arr[pick_idx];
   assign pick_divisor  = divisor_arr[pick_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         rr_ptr_reg     <= '0;
         id_reg         <= '0;
         dividend_reg   <= '0;
         dz_reg         <= 1'b0;
         wd_reg         <= '0;
         ack            <= '0;
         resp_valid     <= 1'b0;
         resp_id        <= '0;
         resp_quotient  <= '0;
         resp_remainder <= '0;
         resp_dz        <= 1'b0;
         resp_err       <= 1'b0;
         div_start      <= 1'b0;
         div_abort      <= 1'b0;
         div_dividend   <= '0;
         div_divisor    <= '0;
      end else begin
         // Pulse outputs default low; result fields hold their last value.
         ack        <= '0;
         resp_valid <= 1'b0;
         div_start  <= 1'b0;
         div_abort  <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               if (pick_valid) begin
                  ack          <= pick_grant;
                  id_reg       <= pick_idx;
                  dividend_reg <= pick_dividend;
                  if (pick_divisor == '0) begin
                     dz_reg    <= 1'b1;
                     state_reg <= ST_RESP;
                  end else begin
                     dz_reg       <= 1'b0;
                     div_dividend <= pick_dividend;
                     div_divisor  <= pick_divisor;
                     state_reg    <= ST_ISSUE;
                  end
               end
            end

            ST_ISSUE: begin
               // Any done level left over from the previous operation is
               // ignored here; only WAIT samples div_done.
               div_start <= 1'b1;
               wd_reg    <= '0;
               state_reg <= ST_WAIT;
            end

            ST_WAIT: begin
               // Completion takes priority over a watchdog expiring on the
               // same cycle.
               if (div_done) begin
                  resp_valid     <= 1'b1;
                  resp_id        <= id_reg;
                  resp_quotient  <= div_quotient;
                  resp_remainder <= div_remainder;
                  resp_dz        <= 1'b0;
                  resp_err       <= 1'b0;
                  state_reg      <= ST_RESP;
               end else if (wd_reg == WDW'(TIMEOUT - 1)) begin
                  div_abort      <= 1'b1;
                  resp_valid     <= 1'b1;
                  resp_id        <= id_reg;
                  resp_quotient  <= '0;
                  resp_remainder <= '0;
                  resp_dz        <= 1'b0;
                  resp_err       <= 1'b1;
                  state_reg      <= ST_RESP;
               end else begin
                  wd_reg <= wd_reg + 1'b1;
               end
            end

            ST_RESP: begin
               // The divide-by-zero answer is emitted from here so that it
               // trails its ack by one cycle; divider results were already
               // emitted on entry from WAIT.
               if (dz_reg) begin
                  resp_valid     <= 1'b1;
                  resp_id        <= id_reg;
                  resp_quotient  <= DZ_WIDE[W-1:0];
                  resp_remainder <= dividend_reg;
                  resp_dz        <= 1'b1;
                  resp_err       <= 1'b0;
               end
               rr_ptr_reg <= (id_reg == IDW'(NREQ - 1)) ? '0 : id_reg + 1'b1;
               state_reg  <= ST_IDLE;
            end

            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule : div_arbiter

// File: tb/tb_div_arbiter.sv
// -----------------------------------------------------------------------------
// tb_div_arbiter
// Directed + randomized bench for div_arbiter with a behavioural divider
// stub (fixed-latency pulse, never-done, or permanent level done).
// -----------------------------------------------------------------------------
module tb_div_arbiter;

   localparam int NREQ    = 2;
   localparam int W       = 8;
   localparam int TIMEOUT = 64;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [NREQ-1:0]         req = '0;
   logic [NREQ*W-1:0]       req_dividend = '0;
   logic [NREQ*W-1:0]       req_divisor = '0;
   logic [NREQ-1:0]         ack;
   logic                    resp_valid;
   logic [$clog2(NREQ)-1:0] resp_id;
   logic [W-1:0]            resp_quotient;
   logic [W-1:0]            resp_remainder;
   logic                    resp_dz;
   logic                    resp_err;
   logic                    div_start;
   logic                    div_abort;
   logic [W-1:0]            div_dividend;
   logic [W-1:0]            div_divisor;
   logic                    div_done;
   logic [W-1:0]            div_quotient;
   logic [W-1:0]            div_remainder;

   always #5 clk = ~clk;

   div_arbiter #(
      .NREQ    (NREQ),
      .W       (W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req            (req),
      .req_dividend   (req_dividend),
      .req_divisor    (req_divisor),
      .ack            (ack),
      .resp_valid     (resp_valid),
      .resp_id        (resp_id),
      .resp_quotient  (resp_quotient),
      .resp_remainder (resp_remainder),
      .resp_dz        (resp_dz),
      .resp_err       (resp_err),
      .div_start      (div_start),
      .div_abort      (div_abort),
      .div_dividend   (div_dividend),
      .div_divisor    (div_divisor),
      .div_done       (div_done),
      .div_quotient   (div_quotient),
      .div_remainder  (div_remainder)
   );

   // ---------------- divider stub ----------------
   // dmode 0: pulse done lat cycles after start; 1: never done; 2: done level
   int          dmode = 0;
   int          lat = 10;
   logic        busy;
   int          cnt;
   logic [W-1:0] qm, rm;

   always @(posedge clk) begin
      if (rst) begin
         div_done <= 1'b0;
         busy     <= 1'b0;
      end else if (dmode == 2) begin
         div_done <= 1'b1;
      end else begin
         div_done <= 1'b0;
         if (div_abort) begin
            busy <= 1'b0;
         end else if (div_start && dmode == 0) begin
            busy <= 1'b1;
            cnt  <= lat;
            qm   <= div_dividend / div_divisor;
            rm   <= div_dividend % div_divisor;
         end else if (busy) begin
            if (cnt <= 1) begin
               div_done <= 1'b1;
               busy     <= 1'b0;
            end else begin
               cnt <= cnt - 1;
            end
         end
      end
   end

   assign div_quotient  = (dmode == 2) ? ((div_divisor != 0) ? div_dividend / div_divisor : '0) : qm;
   assign div_remainder = (dmode == 2) ? ((div_divisor != 0) ? div_dividend % div_divisor : '0) : rm;

   // ---------------- bookkeeping ----------------
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int start_cnt = 0, resp_cnt = 0, overlap = 0;
   int ack_cyc = 0, start_cyc = 0, abort_cyc = 0, done_cyc = 0, resp_cyc = 0;
   logic outstanding = 1'b0;
   logic prev_done = 1'b0;
   int          r_id;
   logic [W-1:0] r_q, r_r;
   logic        r_dz, r_err;
   int          rr_ptr_m = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and record what the DUT showed on that cycle.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (ack != '0) begin
         if (outstanding) overlap++;
         outstanding = 1'b1;
         ack_cyc = cyc;
      end
      if (div_start) begin
         start_cnt++;
         start_cyc = cyc;
      end
      if (div_abort) abort_cyc = cyc;
      if (div_done && !prev_done) done_cyc = cyc;
      prev_done = div_done;
      if (resp_valid) begin
         outstanding = 1'b0;
         resp_cnt++;
         resp_cyc = cyc;
         r_id  = int'(resp_id);
         r_q   = resp_quotient;
         r_r   = resp_remainder;
         r_dz  = resp_dz;
         r_err = resp_err;
      end
   endtask

   task automatic wait_ack(output logic got);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         step();
         if (ack != '0) got = 1'b1;
      end
      check("ack_seen", 32'(got), 32'd1);
   endtask

   task automatic wait_resp(output logic got);
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         step();
         if (resp_valid) got = 1'b1;
      end
      check("resp_seen", 32'(got), 32'd1);
   endtask

   // Reference: round-robin pick from the pointer, wrapping.
   function automatic int model_pick(input logic [NREQ-1:0] r, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return 0;
   endfunction

   // One isolated request from requester id, result checked by the model.
   task automatic txn(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
      logic        got;
      int          g, acyc, s0;
      logic [W-1:0] eq, er;
      logic        edz, eerr;
      req_dividend[id*W +: W] = a;
      req_divisor[id*W +: W]  = b;
      req[id] = 1'b1;
      g = model_pick(req, rr_ptr_m);
      s0 = start_cnt;
      wait_ack(got);
      req[id] = 1'b0;
      check("ack_grant", 32'(ack), 32'(1 << g));
      acyc = ack_cyc;
      wait_resp(got);
      if (b == 0) begin
         eq = '1; er = a; edz = 1'b1; eerr = 1'b0;
      end else if (dmode == 1) begin
         eq = '0; er = '0; edz = 1'b0; eerr = 1'b1;
      end else begin
         eq = a / b; er = a % b; edz = 1'b0; eerr = 1'b0;
      end
      $display("txn id=%0d %0d/%0d mode=%0d -> id=%0d q=%0d r=%0d dz=%0d err=%0d",
               id, a, b, dmode, r_id, r_q, r_r, r_dz, r_err);
      check("resp_id", 32'(r_id), 32'(g));
      check("resp_q", 32'(r_q), 32'(eq));
      check("resp_r", 32'(r_r), 32'(er));
      check("resp_dz", 32'(r_dz), 32'(edz));
      check("resp_err", 32'(r_err), 32'(eerr));
      if (b == 0) begin
         check("dz_no_start", 32'(start_cnt - s0), 32'd0);
         check("dz_latency", 32'(resp_cyc), 32'(acyc + 1));
      end else begin
         check("one_start", 32'(start_cnt - s0), 32'd1);
         check("start_latency", 32'(start_cyc), 32'(acyc + 1));
         if (dmode == 0) check("done_to_resp", 32'(resp_cyc), 32'(done_cyc + 1));
         if (dmode == 1) begin
            check("abort_cycle", 32'(abort_cyc), 32'(start_cyc + TIMEOUT));
            check("abort_resp", 32'(resp_cyc), 32'(abort_cyc));
         end
         if (dmode == 2) check("level_done_resp", 32'(resp_cyc), 32'(start_cyc + 1));
      end
      rr_ptr_m = (g + 1) % NREQ;
   endtask

   initial begin
      logic        got;
      int          g, prev_g;
      logic [W-1:0] ea, eb;

      // ---- reset state ----
      step();
      step();
      check("rst_ctrl", 32'({ack, resp_valid, resp_id, resp_dz, resp_err, div_start, div_abort}), 32'd0);
      check("rst_resp_data", 32'({resp_quotient, resp_remainder}), 32'd0);
      check("rst_div_data", 32'({div_dividend, div_divisor}), 32'd0);
      rst = 1'b0;
      step();

      // ---- single request 59/6, 10-cycle divider ----
      dmode = 0;
      lat = 10;
      txn(0, 8'h3B, 8'h06);

      // ---- both requesters held: grants must alternate ----
      for (int i = 0; i < NREQ; i++) begin
         req_dividend[i*W +: W] = W'($urandom_range(0, 255));
         req_divisor[i*W +: W]  = W'($urandom_range(1, 255));
      end
      req = '1;
      prev_g = -1;
      for (int k = 0; k < 6; k++) begin
         lat = $urandom_range(1, 8);
         g = model_pick(req, rr_ptr_m);
         wait_ack(got);
         check("rr_grant", 32'(ack), 32'(1 << g));
         if (k > 0) check("rr_alternate", 32'(g != prev_g), 32'd1);
         ea = req_dividend[g*W +: W];
         eb = req_divisor[g*W +: W];
         req_dividend[g*W +: W] = W'($urandom_range(0, 255));
         req_divisor[g*W +: W]  = W'($urandom_range(1, 255));
         wait_resp(got);
         if (k == 5) req = '0;
         $display("rr k=%0d grant=%0d %0d/%0d -> id=%0d q=%0d r=%0d", k, g, ea, eb, r_id, r_q, r_r);
         check("rr_id", 32'(r_id), 32'(g));
         check("rr_q", 32'(r_q), 32'(ea / eb));
         check("rr_r", 32'(r_r), 32'(ea % eb));
         rr_ptr_m = (g + 1) % NREQ;
         prev_g = g;
      end
      check("no_overlap_ack", 32'(overlap), 32'd0);

      // ---- divide by zero from requester 1 ----
      txn(1, 8'h2A, 8'h00);

      // ---- hung divider: watchdog, then normal recovery ----
      dmode = 1;
      txn(0, 8'd100, 8'd7);
      dmode = 0;
      lat = 3;
      txn(1, 8'd200, 8'd13);

      // ---- done level held from a prior operation ----
      dmode = 2;
      txn(0, 8'd77, 8'd5);
      txn(1, 8'd250, 8'd9);
      dmode = 0;
      step();
      step();

      // ---- random traffic ----
      for (int k = 0; k < 8; k++) begin
         lat = $urandom_range(1, 12);
         txn($urandom_range(0, NREQ - 1), W'($urandom_range(0, 255)),
             ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom_range(1, 255)));
      end

      // ---- reset during WAIT ----
      dmode = 1;
      req_dividend[0 +: W] = 8'd90;
      req_divisor[0 +: W]  = 8'd4;
      req[0] = 1'b1;
      wait_ack(got);
      req[0] = 1'b0;
      for (int i = 0; i < 6; i++) step();
      #1 rst = 1'b1;
      #1;
      check("midrst_ctrl", 32'({ack, resp_valid, resp_id, resp_dz, resp_err, div_start, div_abort}), 32'd0);
      check("midrst_data", 32'({resp_quotient, resp_remainder, div_dividend, div_divisor}), 32'd0);
      step();
      step();
      rst = 1'b0;
      outstanding = 1'b0;
      rr_ptr_m = 0;
      begin
         int r0;
         r0 = resp_cnt;
         for (int i = 0; i < 80; i++) step();
         check("no_resp_after_rst", 32'(resp_cnt), 32'(r0));
      end
      dmode = 0;
      lat = 4;
      txn(0, 8'd90, 8'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_div_arbiter
